// File: rtl/tis_out_sink.sv
// Host-side sink for a TIS-100 node output handshake: captures {lane, value}
// into a show-ahead circular FIFO and answers each accepted write with a one-cycle ackw.
module tis_out_sink #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ack,
  input  logic [1:0]    wr_port,
  input  logic [7:0]    out0,
  input  logic [7:0]    out1,
  input  logic [7:0]    out2,
  input  logic [7:0]    out3,
  output logic          ackw,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [1:0]    rd_port,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DATA_W = 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   lane_data;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count_q;
  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [1:0]          port_mem [DEPTH];

  always_comb begin
    lane_data = out0;
    case (wr_port)
      2'd0:    lane_data = out0;
      2'd1:    lane_data = out1;
      2'd2:    lane_data = out2;
      default: lane_data = out3;
    endcase
  end

  // Handshake: full is the registered flag, so a pop in the same cycle
  // cannot make room for this cycle's push.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (ack && !full) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:  state_nxt = DROP;
      DROP: begin
        if (!ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ackw    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state <= state_nxt;
      ackw  <= push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= lane_data;
      port_mem[wr_ptr] <= wr_port;
    end
  end

  assign rd_data = data_mem[rd_ptr];
  assign rd_port = port_mem[rd_ptr];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);

endmodule

// File: tb/tb_tis_out_sink.sv
// Bench for tis_out_sink: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based reference model.
module tb_tis_out_sink;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ack = 1'b0;
  logic [1:0]    wr_port = 2'd0;
  logic [7:0]    out0 = 8'd0, out1 = 8'd0, out2 = 8'd0, out3 = 8'd0;
  logic          ackw;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic [1:0]    rd_port;
  logic          empty;
  logic          full;
  logic [AW:0]   count;

  tis_out_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ack(ack), .wr_port(wr_port),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .ackw(ackw), .rd_en(rd_en), .rd_data(rd_data), .rd_port(rd_port),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue of {lane, value}; the node-side rule is
  // "after an acceptance, skip one edge, then wait for an edge with ack low".
  logic [9:0] mq[$];
  int         cool = 0;
  logic       exp_ackw = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic a, input logic [1:0] p,
                            input logic [7:0] dv, input logic rd);
    logic do_push;
    logic do_pop;
    if (r) begin
      mq.delete();
      cool     = 0;
      exp_ackw = 1'b0;
    end else begin
      do_push = (cool == 0) && a && (mq.size() < DEPTH);
      do_pop  = rd && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({p, dv});
      exp_ackw = do_push;
      if (do_push)                cool = 2;
      else if (cool == 2)         cool = 1;
      else if (cool == 1 && !a)   cool = 0;
    end
  endtask

  task automatic model_check();
    chk("ackw", {31'd0, ackw}, {31'd0, exp_ackw});
    chk("count", {29'd0, count}, mq.size());
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    if (mq.size() > 0) begin
      chk("rd_data", {24'd0, rd_data}, {24'd0, mq[0][7:0]});
      chk("rd_port", {30'd0, rd_port}, {30'd0, mq[0][9:8]});
    end
  endtask

  // One clock: drive inputs while clk is low, advance model, check after edge.
  task automatic step(input logic r, input logic a, input logic [1:0] p,
                      input logic [7:0] dv, input logic rd);
    reset   = r;
    ack     = a;
    wr_port = p;
    rd_en   = rd;
    out0 = 8'($urandom); out1 = 8'($urandom);
    out2 = 8'($urandom); out3 = 8'($urandom);
    case (p)
      2'd0: out0 = dv;
      2'd1: out1 = dv;
      2'd2: out2 = dv;
      default: out3 = dv;
    endcase
    model_edge(r, a, p, dv, rd);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  // Node-style write: hold ack until ackw, then two low cycles to re-arm.
  task automatic do_write(input logic [1:0] p, input logic [7:0] dv);
    int n;
    n = 0;
    step(1'b0, 1'b1, p, dv, 1'b0);
    while (!ackw && n < 20) begin
      step(1'b0, 1'b1, p, dv, 1'b0);
      n++;
    end
    chk("write_timeout", {31'd0, ackw}, 32'd1);
    step(1'b0, 1'b0, p, dv, 1'b0);
    step(1'b0, 1'b0, p, dv, 1'b0);
  endtask

  typedef struct {
    logic       r;
    logic       a;
    logic [1:0] p;
    logic [7:0] dv;
    logic       rd;
    logic       e_ackw;
    int         e_count;
    logic       e_empty;
    logic       e_full;
    logic       head;
    logic [7:0] e_data;
    logic [1:0] e_port;
  } vec_t;

  vec_t vt[16];

  initial begin
    // Reset, single write with ack held 8 extra cycles, pops incl. empty pop
    vt[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    vt[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
    for (int i = 2; i < 10; i++)
      vt[i] = '{1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
    vt[10] = '{1'b0, 1'b0, 2'd2, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
    vt[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    vt[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    vt[13] = '{1'b0, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h3C, 2'd1};
    vt[14] = '{1'b0, 1'b1, 2'd1, 8'h3C, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    vt[15] = '{1'b0, 1'b0, 2'd1, 8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step(vt[i].r, vt[i].a, vt[i].p, vt[i].dv, vt[i].rd);
      chk($sformatf("vec%0d_ackw", i), {31'd0, ackw}, {31'd0, vt[i].e_ackw});
      chk($sformatf("vec%0d_count", i), {29'd0, count}, vt[i].e_count);
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e_empty});
      chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vt[i].e_full});
      if (vt[i].head) begin
        chk($sformatf("vec%0d_data", i), {24'd0, rd_data}, {24'd0, vt[i].e_data});
        chk($sformatf("vec%0d_port", i), {30'd0, rd_port}, {30'd0, vt[i].e_port});
      end
    end

    // Fill to full, blocked 5th write, pop releases it
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'(i + 1));
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {29'd0, count}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 2'd1, 8'h05, 1'b0);
      chk("blocked_ackw", {31'd0, ackw}, 32'd0);
    end
    chk("head_before_pop", {24'd0, rd_data}, 32'h01);
    chk("headport_before_pop", {30'd0, rd_port}, 32'd0);
    step(1'b0, 1'b1, 2'd1, 8'h05, 1'b1);
    chk("full_pop_no_push", {29'd0, count}, 32'd3);
    chk("full_pop_ackw", {31'd0, ackw}, 32'd0);
    step(1'b0, 1'b1, 2'd1, 8'h05, 1'b0);
    chk("released_ackw", {31'd0, ackw}, 32'd1);
    chk("released_count", {29'd0, count}, 32'd4);
    step(1'b0, 1'b0, 2'd1, 8'h05, 1'b0);
    step(1'b0, 1'b0, 2'd1, 8'h05, 1'b0);

    // Wrap-around: 10 write/pop pairs
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_write(2'(i % 4), 8'(8'h10 + i));
      chk("wrap_data", {24'd0, rd_data}, 32'(8'h10 + i));
      chk("wrap_count", {29'd0, count}, 32'd1);
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      chk("wrap_drain", {29'd0, count}, 32'd0);
    end

    // Simultaneous push and pop at count=2
    do_write(2'd0, 8'hB1);
    do_write(2'd3, 8'hB2);
    step(1'b0, 1'b1, 2'd2, 8'hB3, 1'b1);
    chk("simul_ackw", {31'd0, ackw}, 32'd1);
    chk("simul_count", {29'd0, count}, 32'd2);
    chk("simul_head", {24'd0, rd_data}, 32'hB2);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("simul_next", {24'd0, rd_data}, 32'hB3);
    chk("simul_nextport", {30'd0, rd_port}, 32'd2);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    chk("empty_pop_count", {29'd0, count}, 32'd0);
    chk("empty_pop_empty", {31'd0, empty}, 32'd1);

    // Reset while in ACK with count=3 and ack held high
    do_write(2'd0, 8'hC1);
    do_write(2'd1, 8'hC2);
    step(1'b0, 1'b1, 2'd2, 8'hC3, 1'b0);
    chk("pre_reset_ackw", {31'd0, ackw}, 32'd1);
    chk("pre_reset_count", {29'd0, count}, 32'd3);
    step(1'b1, 1'b1, 2'd2, 8'hC3, 1'b0);
    chk("rst_ackw", {31'd0, ackw}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    step(1'b0, 1'b1, 2'd3, 8'hC4, 1'b0);
    chk("post_rst_ackw", {31'd0, ackw}, 32'd1);
    chk("post_rst_count", {29'd0, count}, 32'd1);
    chk("post_rst_data", {24'd0, rd_data}, 32'hC4);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           2'($urandom), 8'($urandom), ($urandom_range(0, 9) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tis_out_sink.md
# tis_out_sink

Host-side responder for a TIS-100 node's output handshake. The node drives one of its four 8-bit output lanes and raises `ack`. This block captures the value and lane number into a small FIFO, then returns a one-cycle `ackw` so the node's write completes. A host or testbench drains the FIFO through a show-ahead read port. It sits beside the TIS100 top level, with `ackw` wired straight into the node.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `AW`, default 2: log2(DEPTH); pointer width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- `ack`  in  1  node write request; held high by the node until `ackw` is seen.
- `wr_port`  in  [0:1]  lane being written by the node (0..3); valid while `ack` is high.
- `out0`, `out1`, `out2`, `out3`  in  [0:7] each  node output lanes.
- `ackw`  out  1  write acknowledge to the node; one-cycle registered pulse.
- `rd_en`  in  1  host pop request.
- `rd_data`  out  [0:7]  head entry's data (show-ahead, combinational from storage).
- `rd_port`  out  [0:1]  head entry's lane number.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  [0:AW]  current occupancy, 0..DEPTH.

## Operation
The handshake FSM has three states; reset enters `IDLE`.

- `IDLE`: if `ack`=1 and `full`=0, push {`wr_port`, selected `outN`} at this edge and go to `ACK`.
  - If `ack`=1 and `full`=1, stay in `IDLE`; no push, `ackw` stays low (this backpressures the node).
- `ACK`: `ackw`=1 for exactly this cycle, then go to `DROP`.
- `DROP`: wait for `ack`=0, then go to `IDLE`.
  - The same request is never captured twice.
  - A new request is accepted only after `ack` has been seen low at least one cycle.

Data path:
- Lane data is selected by `wr_port`: 0→`out0`, 1→`out1`, 2→`out2`, 3→`out3`.
- The FIFO is circular. Write and read pointers are AW bits wide and wrap from DEPTH-1 to 0.
- `count` is AW+1 bits. It increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Pop: when `rd_en`=1 and `empty`=0, the read pointer advances.
  - `rd_en` while empty is ignored: no pointer or count change, no error.
- Simultaneous push and pop:
  - When not full, both occur.
  - When full, the pop occurs, but the push decision uses `full` sampled that cycle, so no push happens. The node is accepted on the next `IDLE` cycle.
- `rd_data`/`rd_port` are undefined while `empty`=1. The bench must not check them then.

## Timing
- Reset values: `ackw`=0, `empty`=1, `full`=0, `count`=0, both pointers 0, FSM=`IDLE`. Storage contents are not reset.
- Reset mid-handshake or with `ack` held high:
  - Everything clears; FSM returns to `IDLE`.
  - A still-high `ack` is served as a fresh request on the first post-reset edge.
- Request to acknowledge: `ack` high and sampled in `IDLE` at edge N pushes the entry at edge N, and `ackw` is high during cycle N+1.
- `empty`/`count` reflect the push from cycle N+1.
- Minimum spacing between two accepted writes is 3 cycles (`IDLE`→`ACK`→`DROP` with `ack` already low →`IDLE`). Throughput is one word per 3 cycles.
- Pop latency: with `rd_en` high at edge M, the next head appears on `rd_data` in cycle M+1.
- `full`/`empty`/`count` are registered-consistent: they are derived from count after the edge, never glitching mid-cycle.

## Test plan
- Reset then single write:
  - Stimulus: `ack`=1, `wr_port`=2, `out2`=8'hA5, held until `ackw`.
  - Required: `ackw` high exactly 1 cycle, on the cycle after `ack` is sampled; `count`=1; `rd_data`=A5, `rd_port`=2.
- Fill to full:
  - Stimulus: 4 writes (data 01..04, lanes 0..3), then a 5th write with data 05.
  - Required: `full`=1 after the 4th write. The 5th gets no `ackw` while full. Popping one entry returns 01, lane 0; the 5th is then accepted and `ackw` pulses.
- Wrap-around:
  - Stimulus: 10 write/pop pairs with data 10..19.
  - Required: data read back in order 10..19; `count` never exceeds 1; pointers wrap without loss.
- Held `ack`:
  - Stimulus: `ack` kept high 8 cycles after one write.
  - Required: exactly one push and one `ackw` pulse; `count`=1.
- Simultaneous push and pop at `count`=2:
  - Required: `count` stays 2; order preserved.
  - Also: `rd_en` while empty leaves `count`=0 and `empty`=1.
- Reset asserted in the `ACK` state with `count`=3:
  - Required: next cycle `ackw`=0, `count`=0, `empty`=1.
  - With `ack` still high, a fresh push occurs on the first edge after reset deasserts.
